// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-memory transaction per accepted op, with byte-lane
// alignment, load extension, misalignment/illegal-op detection and a bounded wait for ack.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    input  logic                      is_load_i,
    input  logic                      is_store_i,
    input  logic [2:0]                funct3_i,
    input  logic [31:0]               addr_i,
    input  logic [31:0]               store_data_i,
    input  logic [4:0]                rd_i,
    output logic                      req_ready_o,
    output logic                      stall_o,
    load_store_unit_if.master         mem,
    output logic                      wb_valid_o,
    output logic [4:0]                wb_rd_o,
    output logic [31:0]               wb_data_o,
    output logic                      store_done_o,
    output logic                      err_o
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic        memReq_q, memReq_d;
    logic        memWe_q, memWe_d;
    logic [31:0] memAddr_q, memAddr_d;
    logic [3:0]  memBe_q, memBe_d;
    logic [31:0] memWdata_q, memWdata_d;
    logic        isLoad_q, isLoad_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  byteOff_q, byteOff_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  timeout_q, timeout_d;
    logic        wbValid_q, wbValid_d;
    logic [4:0]  wbRd_q, wbRd_d;
    logic [31:0] wbData_q, wbData_d;
    logic        storeDone_q, storeDone_d;
    logic        err_q, err_d;

    logic        accept;
    logic        legalOp;
    logic        misaligned;
    logic [3:0]  laneBe;
    logic [31:0] laneWdata;
    logic [31:0] lane;
    logic [31:0] loadResult;

    assign accept = (state_q == IDLE) && req_valid_i && (is_load_i || is_store_i);

    always_comb begin
        legalOp    = 1'b0;
        misaligned = 1'b0;
        laneBe     = 4'b1111;
        laneWdata  = store_data_i;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: legalOp = 1'b1;
            3'b100, 3'b101:         legalOp = is_load_i;
            default:                legalOp = 1'b0;
        endcase
        case (funct3_i[1:0])
            2'b00: begin
                laneBe    = 4'b0001 << addr_i[1:0];
                laneWdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                misaligned = addr_i[0];
                laneBe     = addr_i[1] ? 4'b1100 : 4'b0011;
                laneWdata  = {2{store_data_i[15:0]}};
            end
            default: misaligned = (addr_i[1:0] != 2'b00);
        endcase
    end

    // Shift the addressed byte/halfword down to bit 0 before extension.
    assign lane = mem.mem_rdata >> {byteOff_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  loadResult = {{24{lane[7]}}, lane[7:0]};
            3'b100:  loadResult = {24'd0, lane[7:0]};
            3'b001:  loadResult = {{16{lane[15]}}, lane[15:0]};
            3'b101:  loadResult = {16'd0, lane[15:0]};
            default: loadResult = lane;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        memReq_d    = memReq_q;
        memWe_d     = memWe_q;
        memAddr_d   = memAddr_q;
        memBe_d     = memBe_q;
        memWdata_d  = memWdata_q;
        isLoad_d    = isLoad_q;
        funct3_d    = funct3_q;
        byteOff_d   = byteOff_q;
        rd_d        = rd_q;
        timeout_d   = timeout_q;
        wbValid_d   = 1'b0;
        wbRd_d      = wbRd_q;
        wbData_d    = wbData_q;
        storeDone_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!legalOp || misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        memReq_d   = 1'b1;
                        memWe_d    = is_store_i;
                        memAddr_d  = {addr_i[31:2], 2'b00};
                        memBe_d    = laneBe;
                        memWdata_d = laneWdata;
                        isLoad_d   = is_load_i;
                        funct3_d   = funct3_i;
                        byteOff_d  = addr_i[1:0];
                        rd_d       = rd_i;
                        timeout_d  = 8'd0;
                    end
                end
            end
            default: begin
                // An ack on the final permitted cycle still counts as a normal completion.
                if (mem.mem_ack) begin
                    state_d  = IDLE;
                    memReq_d = 1'b0;
                    if (isLoad_q) begin
                        wbValid_d = 1'b1;
                        wbRd_d    = rd_q;
                        wbData_d  = loadResult;
                    end else begin
                        storeDone_d = 1'b1;
                    end
                end else if (timeout_q == LAST_WAIT) begin
                    state_d  = IDLE;
                    memReq_d = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    timeout_d = timeout_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= 32'd0;
            memBe_q     <= 4'd0;
            memWdata_q  <= 32'd0;
            isLoad_q    <= 1'b0;
            funct3_q    <= 3'd0;
            byteOff_q   <= 2'd0;
            rd_q        <= 5'd0;
            timeout_q   <= 8'd0;
            wbValid_q   <= 1'b0;
            wbRd_q      <= 5'd0;
            wbData_q    <= 32'd0;
            storeDone_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            memReq_q    <= memReq_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memBe_q     <= memBe_d;
            memWdata_q  <= memWdata_d;
            isLoad_q    <= isLoad_d;
            funct3_q    <= funct3_d;
            byteOff_q   <= byteOff_d;
            rd_q        <= rd_d;
            timeout_q   <= timeout_d;
            wbValid_q   <= wbValid_d;
            wbRd_q      <= wbRd_d;
            wbData_q    <= wbData_d;
            storeDone_q <= storeDone_d;
            err_q       <= err_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign stall_o       = ~req_ready_o;
    assign mem.mem_req   = memReq_q;
    assign mem.mem_we    = memWe_q;
    assign mem.mem_addr  = memAddr_q;
    assign mem.mem_be    = memBe_q;
    assign mem.mem_wdata = memWdata_q;
    assign wb_valid_o    = wbValid_q;
    assign wb_rd_o       = wbRd_q;
    assign wb_data_o     = wbData_q;
    assign store_done_o  = storeDone_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads with extension, error cases, timeout and reset.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        req_ready;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        store_done;
    logic        err;

    int passCount = 0;
    int checkCount = 0;
    int reqCycles;

    load_store_unit_if memBus();

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .store_data_i (store_data),
        .rd_i         (rd),
        .req_ready_o  (req_ready),
        .stall_o      (stall),
        .mem          (memBus),
        .wb_valid_o   (wb_valid),
        .wb_rd_o      (wb_rd),
        .wb_data_o    (wb_data),
        .store_done_o (store_done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Present one op for a single cycle; it is accepted at the edge inside this task.
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
        req_valid  = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        rd         = r;
        stepCycle();
        req_valid  = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
    endtask

    task automatic ackWith(input logic [31:0] rdata);
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = rdata;
        stepCycle();
        memBus.mem_ack   = 1'b0;
    endtask

    task automatic loadCheck(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rdata, input logic [3:0] expBe, input logic [31:0] expData);
        applyStimulus(1'b1, 1'b0, f3, a, 32'd0, 5'd7);
        checkOutput({tag, "_be"}, {28'd0, memBus.mem_be}, {28'd0, expBe});
        checkOutput({tag, "_we"}, {31'd0, memBus.mem_we}, 32'd0);
        ackWith(rdata);
        checkOutput({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        checkOutput({tag, "_data"}, wb_data, expData);
    endtask

    initial begin
        memBus.mem_ack   = 1'b0;
        memBus.mem_rdata = 32'd0;
        stepCycle();
        stepCycle();
        checkOutput("rst_req", {31'd0, memBus.mem_req}, 32'd0);
        checkOutput("rst_addr", memBus.mem_addr, 32'd0);
        checkOutput("rst_be", {28'd0, memBus.mem_be}, 32'd0);
        checkOutput("rst_wdata", memBus.mem_wdata, 32'd0);
        checkOutput("rst_pulses", {29'd0, wb_valid, store_done, err}, 32'd0);
        checkOutput("rst_wbdata", wb_data, 32'd0);
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        stepCycle();

        // SW with ack in the first ACCESS cycle, then a back-to-back LW.
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0);
        checkOutput("sw_req", {31'd0, memBus.mem_req}, 32'd1);
        checkOutput("sw_we", {31'd0, memBus.mem_we}, 32'd1);
        checkOutput("sw_be", {28'd0, memBus.mem_be}, 32'h0000_000F);
        checkOutput("sw_wdata", memBus.mem_wdata, 32'hDEAD_BEEF);
        checkOutput("sw_addr", memBus.mem_addr, 32'h0000_0100);
        checkOutput("sw_stall", {30'd0, stall, req_ready}, 32'h2);
        ackWith(32'd0);
        checkOutput("sw_done", {29'd0, wb_valid, store_done, err}, 32'h2);
        checkOutput("sw_reqdrop", {31'd0, memBus.mem_req}, 32'd0);
        checkOutput("sw_ready", {31'd0, req_ready}, 32'd1);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 5'd5);
        checkOutput("lw_b2b_req", {31'd0, memBus.mem_req}, 32'd1);
        checkOutput("lw_b2b_pulse", {31'd0, store_done}, 32'd0);
        ackWith(32'hDEAD_BEEF);
        checkOutput("lw_wbv", {31'd0, wb_valid}, 32'd1);
        checkOutput("lw_rd", {27'd0, wb_rd}, 32'd5);
        checkOutput("lw_data", wb_data, 32'hDEAD_BEEF);
        stepCycle();
        checkOutput("lw_pulse_end", {31'd0, wb_valid}, 32'd0);

        // SB to the top byte lane.
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd0);
        checkOutput("sb_be", {28'd0, memBus.mem_be}, 32'h0000_0008);
        checkOutput("sb_wdata", memBus.mem_wdata, 32'hABAB_ABAB);
        checkOutput("sb_addr", memBus.mem_addr, 32'h0000_0100);
        ackWith(32'd0);
        checkOutput("sb_done", {31'd0, store_done}, 32'd1);

        // SH to the upper half.
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h1234_5678, 5'd0);
        checkOutput("sh_be", {28'd0, memBus.mem_be}, 32'h0000_000C);
        checkOutput("sh_wdata", memBus.mem_wdata, 32'h5678_5678);
        ackWith(32'd0);

        // Load extraction and extension.
        loadCheck("lb", 3'b000, 32'h0000_0102, 32'h12F4_5678, 4'b0100, 32'hFFFF_FFF4);
        loadCheck("lbu", 3'b100, 32'h0000_0102, 32'h12F4_5678, 4'b0100, 32'h0000_00F4);
        loadCheck("lh", 3'b001, 32'h0000_0102, 32'h12F4_5678, 4'b1100, 32'h0000_12F4);
        loadCheck("lh_neg", 3'b001, 32'h0000_0102, 32'h8000_0000, 4'b1100, 32'hFFFF_8000);
        loadCheck("lhu", 3'b101, 32'h0000_0102, 32'h8000_0000, 4'b1100, 32'h0000_8000);
        loadCheck("lb0", 3'b000, 32'h0000_0100, 32'h0000_0085, 4'b0001, 32'hFFFF_FF85);

        // Ack while idle must be ignored.
        memBus.mem_ack = 1'b1;
        stepCycle();
        memBus.mem_ack = 1'b0;
        checkOutput("idle_ack", {29'd0, wb_valid, store_done, err}, 32'd0);

        // Error cases: one-cycle err, no memory request.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'd0, 5'd1);
        checkOutput("lw_mis_err", {31'd0, err}, 32'd1);
        checkOutput("lw_mis_req", {30'd0, memBus.mem_req, req_ready}, 32'h1);
        stepCycle();
        checkOutput("lw_mis_errend", {31'd0, err}, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'd0, 5'd1);
        checkOutput("f3_ill_err", {30'd0, err, memBus.mem_req}, 32'h2);
        applyStimulus(1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'd0, 5'd1);
        checkOutput("sbu_ill_err", {30'd0, err, memBus.mem_req}, 32'h2);
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_1001, 32'd0, 5'd1);
        checkOutput("sh_mis_err", {30'd0, err, memBus.mem_req}, 32'h2);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h0000_1001, 32'd0, 5'd1);
        checkOutput("noop_ignored", {30'd0, err, memBus.mem_req}, 32'h0);

        // Timeout with no ack: mem_req high exactly 8 cycles.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'd0, 5'd2);
        reqCycles = 0;
        while (memBus.mem_req && reqCycles < 20) begin
            reqCycles++;
            stepCycle();
        end
        checkOutput("to_cycles", 32'(reqCycles), 32'd8);
        checkOutput("to_err", {29'd0, err, wb_valid, req_ready}, 32'h5);
        stepCycle();
        checkOutput("to_errend", {31'd0, err}, 32'd0);

        // Ack on the last permitted cycle wins.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'd0, 5'd3);
        for (int i = 0; i < 7; i++) stepCycle();
        checkOutput("to8_req", {31'd0, memBus.mem_req}, 32'd1);
        ackWith(32'h1357_9BDF);
        checkOutput("to8_done", {30'd0, wb_valid, err}, 32'h2);
        checkOutput("to8_data", wb_data, 32'h1357_9BDF);

        // Reset in the third ACCESS cycle, then a normal load.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 5'd4);
        stepCycle();
        stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("rst_mid", {28'd0, memBus.mem_req, wb_valid, err, req_ready}, 32'h1);
        rst = 1'b0;
        stepCycle();
        checkOutput("rst_mid_quiet", {29'd0, wb_valid, err, store_done}, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 5'd9);
        checkOutput("post_rst_req", {31'd0, memBus.mem_req}, 32'd1);
        ackWith(32'hCAFE_F00D);
        checkOutput("post_rst_data", wb_data, 32'hCAFE_F00D);
        checkOutput("post_rst_rd", {27'd0, wb_rd}, 32'd9);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
